// File: rtl/bus_pkg.sv
// Shared bus definitions used by the bus driver and the bus receiver.
package bus_pkg;

    localparam int BUS_W    = 4;
    localparam int RX_DEPTH = 4;

    typedef logic [BUS_W-1:0] bus_word_t;

endpackage

// File: rtl/bus_fifo_mem.sv
// Receive FIFO storage: synchronous write port, asynchronous read port.
module bus_fifo_mem #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bus_rx.sv
// Bus receive end: captures strobed words into a FWFT FIFO with
// valid/ready output, back-pressure and a saturating drop counter.
module bus_rx
    import bus_pkg::*;
#(
    parameter int WIDTH = BUS_W,
    parameter int DEPTH = RX_DEPTH,
    parameter int CNT_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           bus_data,
    input  logic                       bus_valid,
    output logic                       bus_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [CNT_W-1:0]           drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_nxt;
    logic [LVL_W-1:0] lvl_nxt;
    logic [WIDTH-1:0] rd_word;
    logic             wr;
    logic             rd;
    logic             drop;
    logic             bypass;

    assign bus_ready = (level != LVL_W'(DEPTH));
    assign out_valid = (level != '0);

    assign wr   = bus_valid & bus_ready;
    assign rd   = out_valid & out_ready;
    assign drop = bus_valid & ~bus_ready;

    assign rd_nxt = rd ? rd_ptr + PTR_W'(1) : rd_ptr;

    // The new head is the word being written when the FIFO drains to
    // empty before this write lands.
    assign bypass = wr && (level == (rd ? LVL_W'(1) : LVL_W'(0)));

    always_comb begin
        lvl_nxt = level;
        case ({wr, rd})
            2'b10:   lvl_nxt = level + LVL_W'(1);
            2'b01:   lvl_nxt = level - LVL_W'(1);
            default: lvl_nxt = level;
        endcase
    end

    bus_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr),
        .waddr (wr_ptr),
        .wdata (bus_data),
        .raddr (rd_nxt),
        .rdata (rd_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            drop_cnt <= '0;
            out_data <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_nxt;
            level  <= lvl_nxt;
            if (drop && drop_cnt != '1) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
            if (lvl_nxt != '0) begin
                out_data <= bypass ? bus_data : rd_word;
            end
        end
    end

endmodule

// File: tb/tb_bus_rx.sv
// Self-checking bench for bus_rx: vector table, directed corners,
// and random traffic against a queue-based reference model.
module tb_bus_rx;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] bus_data;
    logic       bus_valid;
    logic       bus_ready;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] level;
    logic [3:0] drop_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    logic [3:0] mq[$];
    int         mdrop = 0;

    typedef struct {
        logic       bv;
        logic [3:0] bd;
        logic       ord;
        int         lvl;
        logic       ov;
        logic [3:0] od;
        logic       br;
        int         drop;
    } vec_t;

    vec_t vt[$];

    bus_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_data  (bus_data),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("m_level", int'(level), mq.size());
        chk("m_out_valid", int'(out_valid), int'(mq.size() != 0));
        chk("m_bus_ready", int'(bus_ready), int'(mq.size() != DEPTH));
        chk("m_drop_cnt", int'(drop_cnt), mdrop);
        if (mq.size() != 0) chk("m_out_data", int'(out_data), int'(mq[0]));
    endtask

    task automatic step(input logic bv, input logic [3:0] bd, input logic ord);
        bit rd, wr;
        bus_valid = bv;
        bus_data  = bd;
        out_ready = ord;
        rd = ord && (mq.size() != 0);
        wr = bv && (mq.size() < DEPTH);
        if (bv && !wr && mdrop < 15) mdrop++;
        @(posedge clk);
        #1;
        if (rd) void'(mq.pop_front());
        if (wr) mq.push_back(bd);
        check_model();
    endtask

    task automatic add(input logic bv, input logic [3:0] bd, input logic ord,
                       input int lvl, input logic ov, input logic [3:0] od,
                       input logic br, input int drop);
        vec_t v;
        v.bv = bv; v.bd = bd; v.ord = ord; v.lvl = lvl;
        v.ov = ov; v.od = od; v.br = br; v.drop = drop;
        vt.push_back(v);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_level"}, int'(level), 0);
        chk({tag, "_bus_ready"}, int'(bus_ready), 1);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_data"}, int'(out_data), 0);
        chk({tag, "_drop_cnt"}, int'(drop_cnt), 0);
    endtask

    // Assert reset between edges, check immediately, release mid-cycle.
    task automatic async_reset(input string tag);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_vals(tag);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        mq.delete();
        mdrop = 0;
    endtask

    initial begin
        rst_n     = 1'b0;
        bus_valid = 1'b0;
        bus_data  = '0;
        out_ready = 1'b0;
        #2;
        check_reset_vals("in_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset then idle.
        step(0, 4'h0, 0);
        step(0, 4'h5, 1);
        check_reset_vals("idle");

        // Single transfer, fill/overflow/drain, simultaneous, full read.
        add(1, 4'hA, 0, 1, 1, 4'hA, 1, 0);
        add(0, 4'h0, 1, 0, 0, 4'h0, 1, 0);
        add(1, 4'h1, 0, 1, 1, 4'h1, 1, 0);
        add(1, 4'h2, 0, 2, 1, 4'h1, 1, 0);
        add(1, 4'h3, 0, 3, 1, 4'h1, 1, 0);
        add(1, 4'h4, 0, 4, 1, 4'h1, 0, 0);
        add(1, 4'h5, 0, 4, 1, 4'h1, 0, 1);
        add(1, 4'h6, 0, 4, 1, 4'h1, 0, 2);
        add(0, 4'h0, 1, 3, 1, 4'h2, 1, 2);
        add(0, 4'h0, 1, 2, 1, 4'h3, 1, 2);
        add(0, 4'h0, 1, 1, 1, 4'h4, 1, 2);
        add(0, 4'h0, 1, 0, 0, 4'h0, 1, 2);
        add(1, 4'h7, 0, 1, 1, 4'h7, 1, 2);
        add(1, 4'h8, 0, 2, 1, 4'h7, 1, 2);
        add(1, 4'h9, 1, 2, 1, 4'h8, 1, 2);
        add(1, 4'h9, 1, 2, 1, 4'h9, 1, 2);
        add(1, 4'h9, 1, 2, 1, 4'h9, 1, 2);
        add(1, 4'hA, 0, 3, 1, 4'h9, 1, 2);
        add(1, 4'hB, 0, 4, 1, 4'h9, 0, 2);
        add(1, 4'hF, 1, 3, 1, 4'h9, 1, 3);
        add(0, 4'h0, 1, 2, 1, 4'hA, 1, 3);
        add(0, 4'h0, 1, 1, 1, 4'hB, 1, 3);
        add(0, 4'h0, 1, 0, 0, 4'h0, 1, 3);

        foreach (vt[i]) begin
            step(vt[i].bv, vt[i].bd, vt[i].ord);
            chk($sformatf("vec%0d_level", i), int'(level), vt[i].lvl);
            chk($sformatf("vec%0d_out_valid", i), int'(out_valid), int'(vt[i].ov));
            chk($sformatf("vec%0d_bus_ready", i), int'(bus_ready), int'(vt[i].br));
            chk($sformatf("vec%0d_drop_cnt", i), int'(drop_cnt), vt[i].drop);
            if (vt[i].ov) chk($sformatf("vec%0d_out_data", i), int'(out_data), int'(vt[i].od));
        end

        // Stream 0..15 at full rate through the wrapping pointers.
        for (int i = 0; i < 16; i++) begin
            step(1, 4'(i), 1);
            chk("stream_data", int'(out_data), i);
            chk("stream_level", int'(level), 1);
        end
        step(0, 4'h0, 1);
        chk("stream_drops", int'(drop_cnt), 3);

        // Saturate the drop counter.
        for (int i = 0; i < 24; i++) step(1, 4'(i), 0);
        chk("sat_drop_cnt", int'(drop_cnt), 15);
        chk("sat_level", int'(level), 4);

        // Random traffic against the model.
        async_reset("rst_a");
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 7), 4'($urandom), $urandom_range(0, 1) == 1);
        end

        // Asynchronous reset at level 3.
        async_reset("rst_b");
        for (int i = 0; i < 3; i++) step(1, 4'(i + 3), 0);
        chk("pre_rst_level", int'(level), 3);
        async_reset("rst_mid");
        step(1, 4'hC, 0);
        chk("post_rst_data", int'(out_data), 12);
        chk("post_rst_level", int'(level), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_rx.md
# bus_rx

Receive end of the 4-bit shared data bus. The block captures words strobed onto the bus by the driving side and buffers them in a small first-word-fall-through FIFO. It hands them to a downstream consumer with a valid/ready handshake, applies back-pressure to the bus side, and counts words dropped while full.

## Interface

Parameters:
- WIDTH, 4, bus data width in bits.
- DEPTH, 4, FIFO depth in words; power of two, at least 2.
- CNT_W, 4, width of the drop counter, which saturates at all-ones.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- bus_data  input  WIDTH  word currently driven on the bus.
- bus_valid  input  1  bus strobe; high means bus_data holds a word to capture this cycle.
- bus_ready  output  1  high when the FIFO can accept a word.
- out_data  output  WIDTH  oldest buffered word.
- out_valid  output  1  high when out_data holds a word.
- out_ready  input  1  consumer accepts out_data this cycle.
- level  output  $clog2(DEPTH+1)  number of buffered words, 0..DEPTH.
- drop_cnt  output  CNT_W  number of strobes lost while full; saturating.

## Operation

- Write: a write occurs when bus_valid and bus_ready are both high. bus_data is stored at wr_ptr, and wr_ptr increments modulo DEPTH.
- Read: a read occurs when out_valid and out_ready are both high. rd_ptr increments modulo DEPTH.
- Output data: out_data is the memory word at rd_ptr. When the FIFO is empty, out_data holds its last value and is don't-care.
- Flags:
  - bus_ready = (level != DEPTH).
  - out_valid = (level != 0).
  - Both flags are decoded from the registered level with no combinational path from any input.
- Simultaneous read and write (level strictly between 0 and DEPTH): both occur and level is unchanged.
- Full: bus_ready is low, so no write happens, even if a read happens in the same cycle. Only the read takes effect, and level decrements.
- Empty: out_valid is low, and out_ready is ignored.
- Overflow: bus_valid high with bus_ready low increments drop_cnt by 1. drop_cnt sticks at 2^CNT_W-1. The word is discarded.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. Full/empty status comes from level, not from pointer compare.
- Reset (asynchronous, mid-operation included):
  - wr_ptr, rd_ptr, level and drop_cnt go to 0.
  - bus_ready goes to 1, out_valid to 0, out_data to 0.
  - Buffered words are lost, and memory contents are not cleared.
  - The first write is possible on the first rising edge after rst_n deasserts.

## Timing

- Write-to-output latency is 1 cycle. A word captured at edge N appears on out_data/out_valid after edge N, if the FIFO was empty.
- Throughput is one write and one read per cycle.
- bus_ready deasserts in the cycle after the write that fills the FIFO. It reasserts in the cycle after the first read from full.
- level and drop_cnt update on the same edge as the write, read or drop that changes them.
- The consumer must hold out_ready stable only within a cycle. There is no multi-cycle hold requirement.

## Structure

- Shared package bus_pkg:
  - BUS_W = 4 and RX_DEPTH = 4 defaults.
  - A bus_word_t typedef, logic [BUS_W-1:0].
  - Shared with the bus driver block.
- Sub-module bus_fifo_mem: DEPTH x WIDTH register array with a synchronous write port and an asynchronous read port.
- Pointers, level, flags and drop_cnt live in bus_rx.

## Test plan

- Reset then idle:
  - bus_ready=1, out_valid=0, level=0, drop_cnt=0 after reset.
  - Outputs hold with bus_valid=0.
- Single transfer:
  - Write 4'hA with out_ready=0 gives out_valid=1, out_data=A, level=1 the next cycle.
  - Pulse out_ready gives level=0, out_valid=0.
- Fill and overflow:
  - Write 1,2,3,4 then 5,6 with out_ready=0 gives bus_ready=0 after the fourth write, level=4, drop_cnt=2.
  - Draining then yields 1,2,3,4 in order.
- Simultaneous read and write:
  - At level=2 holding 7,8, assert bus_valid with 9 and out_ready for 3 cycles. level stays 2 and out_data sequence is 7,8,9.
  - At full, assert both. Only the read happens, level=3, and drop_cnt increments.
- Wrap and saturation:
  - Stream 0..15 at one word per cycle with out_ready=1. Output is 0..15 in order with no drops.
  - Force 20 strobes while full. drop_cnt=15.
- Asynchronous reset mid-stream:
  - Drop rst_n between clock edges at level=3. Outputs go to reset values immediately.
  - After release, write 4'hC. out_data=C with level=1.
